// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory initiator with alignment check, store lane steering, load extension and stall.
module mem_access_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] AluRes,
  input  logic [31:0] InputData,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  MemRead,
  output logic        MemStall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        MisalignErr,
  output logic        MemReq,
  output logic        MemWe,
  output logic [29:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWData,
  input  logic        MemReady,
  input  logic [31:0] MemRData
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, stateNext;
  logic isWr, isRd, access, isWord, isHalf, misalign, accept;
  logic [3:0] be;
  logic [31:0] wData, ldVal;
  logic [2:0] ldOp;
  logic [1:0] off;
  logic [7:0] rdByte;
  logic [15:0] rdHalf;
  always_comb begin
    isWr = MemWrite != 2'd0;
    isRd = !isWr && MemRead != 3'd0 && MemRead < 3'd6;
    access = isWr || isRd;
    isWord = isWr ? MemWrite == 2'd3 : MemRead == 3'd5;
    isHalf = isWr ? MemWrite == 2'd2 : (MemRead == 3'd3 || MemRead == 3'd4);
    misalign = isWord ? |AluRes[1:0] : isHalf && AluRes[0];
    accept = state == IDLE && access && !misalign;
    be = MemWrite == 2'd1 ? 4'b0001 << AluRes[1:0] :
         MemWrite == 2'd2 ? (AluRes[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wData = MemWrite == 2'd1 ? {4{InputData[7:0]}} :
            MemWrite == 2'd2 ? {2{InputData[15:0]}} :
            MemWrite == 2'd3 ? InputData : 32'd0;
    rdByte = MemRData[{off, 3'b000} +: 8];
    rdHalf = off[1] ? MemRData[31:16] : MemRData[15:0];
    ldVal = ldOp == 3'd1 ? {{24{rdByte[7]}}, rdByte} :
            ldOp == 3'd2 ? {24'd0, rdByte} :
            ldOp == 3'd3 ? {{16{rdHalf[15]}}, rdHalf} :
            ldOp == 3'd4 ? {16'd0, rdHalf} : MemRData;
    stateNext = state == IDLE ? (accept ? REQ : IDLE) :
                state == REQ ? (MemReady ? DONE : REQ) : IDLE;
    MemStall = accept || state == REQ;
    MemReq = state == REQ;
    LoadValid = state == DONE && !MemWe;
  end
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else state <= stateNext;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      MisalignErr <= 1'b0;
      LoadData <= 32'd0;
      MemWe <= 1'b0;
      MemAddr <= 30'd0;
      MemBe <= 4'd0;
      MemWData <= 32'd0;
      ldOp <= 3'd0;
      off <= 2'd0;
    end else begin
      MisalignErr <= state == IDLE && access && misalign;
      if (accept) begin
        MemAddr <= AluRes[31:2];
        MemWe <= isWr;
        MemBe <= be;
        MemWData <= wData;
        ldOp <= isWr ? 3'd0 : MemRead;
        off <= AluRes[1:0];
      end
      if (state == REQ && MemReady && !MemWe) LoadData <= ldVal;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] AluRes = '0;
  logic [31:0] InputData = '0;
  logic [1:0]  MemWrite = '0;
  logic [2:0]  MemRead = '0;
  logic        MemStall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        MisalignErr;
  logic        MemReq;
  logic        MemWe;
  logic [29:0] MemAddr;
  logic [3:0]  MemBe;
  logic [31:0] MemWData;
  logic        MemReady = 1'b0;
  logic [31:0] MemRData = '0;
  int n_checks = 0;
  int n_fail = 0;
  int stall_cnt;
  int valid_cnt;
  mem_access_unit dut (
    .Clock(Clock), .Reset(Reset), .AluRes(AluRes), .InputData(InputData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemStall(MemStall), .LoadData(LoadData),
    .LoadValid(LoadValid), .MisalignErr(MisalignErr), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData), .MemReady(MemReady),
    .MemRData(MemRData)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic do_load(input string tag, input logic [2:0] rd, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    MemRead = rd;
    AluRes = addr;
    MemRData = rdata;
    MemReady = 1'b1;
    #1;
    check({tag, " t0 stall"}, 32'(MemStall), 32'd1);
    step();
    check({tag, " t1 req"}, 32'(MemReq), 32'd1);
    check({tag, " t1 we"}, 32'(MemWe), 32'd0);
    check({tag, " t1 be"}, 32'(MemBe), 32'hf);
    check({tag, " t1 addr"}, 32'(MemAddr), addr >> 2);
    check({tag, " t1 valid"}, 32'(LoadValid), 32'd0);
    step();
    MemRead = 3'd0;
    check({tag, " t2 valid"}, 32'(LoadValid), 32'd1);
    check({tag, " t2 data"}, LoadData, exp);
    check({tag, " t2 stall"}, 32'(MemStall), 32'd0);
    check({tag, " t2 req"}, 32'(MemReq), 32'd0);
    step();
    check({tag, " t3 valid"}, 32'(LoadValid), 32'd0);
    check({tag, " t3 hold"}, LoadData, exp);
  endtask
  task automatic do_store(input string tag, input logic [1:0] wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    MemWrite = wr;
    AluRes = addr;
    InputData = data;
    MemReady = 1'b1;
    #1;
    check({tag, " t0 stall"}, 32'(MemStall), 32'd1);
    step();
    check({tag, " t1 req"}, 32'(MemReq), 32'd1);
    check({tag, " t1 stall"}, 32'(MemStall), 32'd1);
    check({tag, " t1 we"}, 32'(MemWe), 32'd1);
    check({tag, " t1 addr"}, 32'(MemAddr), addr >> 2);
    check({tag, " t1 be"}, 32'(MemBe), 32'(exp_be));
    check({tag, " t1 wdata"}, MemWData, exp_wd);
    step();
    MemWrite = 2'd0;
    MemRead = 3'd0;
    check({tag, " t2 stall"}, 32'(MemStall), 32'd0);
    check({tag, " t2 req"}, 32'(MemReq), 32'd0);
    check({tag, " t2 valid"}, 32'(LoadValid), 32'd0);
    step();
  endtask
  initial begin
    step();
    step();
    check("rst stall", 32'(MemStall), 32'd0);
    check("rst ldata", LoadData, 32'd0);
    check("rst valid", 32'(LoadValid), 32'd0);
    check("rst mis", 32'(MisalignErr), 32'd0);
    check("rst req", 32'(MemReq), 32'd0);
    check("rst we", 32'(MemWe), 32'd0);
    check("rst addr", 32'(MemAddr), 32'd0);
    check("rst be", 32'(MemBe), 32'd0);
    check("rst wdata", MemWData, 32'd0);
    Reset = 1'b0;
    step();
    do_store("sb", 2'd1, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    do_store("sh", 2'd2, 32'h42, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF);
    do_store("sb0", 2'd1, 32'h200, 32'h0000003C, 4'b0001, 32'h3C3C3C3C);
    MemRead = 3'd5;
    do_store("sw+lw", 2'd3, 32'h40, 32'h01020304, 4'b1111, 32'h01020304);
    do_load("lb", 3'd1, 32'h102, 32'h12F03456, 32'hFFFFFFF0);
    do_load("lbu", 3'd2, 32'h102, 32'h12F03456, 32'h000000F0);
    do_load("lh", 3'd3, 32'h206, 32'h80017FFF, 32'hFFFF8001);
    do_load("lhu", 3'd4, 32'h204, 32'h80017FFF, 32'h00007FFF);
    do_load("lw", 3'd5, 32'h300, 32'hDEADBEEF, 32'hDEADBEEF);
    MemRead = 3'd5;
    AluRes = 32'h101;
    MemReady = 1'b1;
    #1;
    check("mis lw t0 stall", 32'(MemStall), 32'd0);
    check("mis lw t0 err", 32'(MisalignErr), 32'd0);
    step();
    MemRead = 3'd0;
    check("mis lw t1 err", 32'(MisalignErr), 32'd1);
    check("mis lw t1 req", 32'(MemReq), 32'd0);
    check("mis lw t1 stall", 32'(MemStall), 32'd0);
    step();
    check("mis lw t2 err", 32'(MisalignErr), 32'd0);
    check("mis lw t2 req", 32'(MemReq), 32'd0);
    check("mis lw ldata", LoadData, 32'hDEADBEEF);
    MemWrite = 2'd2;
    AluRes = 32'h41;
    #1;
    check("mis sh t0 stall", 32'(MemStall), 32'd0);
    step();
    MemWrite = 2'd0;
    check("mis sh t1 err", 32'(MisalignErr), 32'd1);
    check("mis sh t1 req", 32'(MemReq), 32'd0);
    step();
    check("mis sh t2 err", 32'(MisalignErr), 32'd0);
    stall_cnt = 0;
    MemWrite = 2'd3;
    AluRes = 32'h40;
    InputData = 32'hCAFEF00D;
    MemReady = 1'b0;
    #1;
    stall_cnt += int'(MemStall);
    for (int i = 0; i < 6; i++) begin
      step();
      MemReady = (i == 5);
      stall_cnt += int'(MemStall);
      check($sformatf("sw wait req %0d", i), 32'(MemReq), 32'd1);
      check($sformatf("sw wait addr %0d", i), 32'(MemAddr), 32'h10);
      check($sformatf("sw wait be %0d", i), 32'(MemBe), 32'hf);
      check($sformatf("sw wait wdata %0d", i), MemWData, 32'hCAFEF00D);
    end
    step();
    MemWrite = 2'd0;
    MemReady = 1'b0;
    stall_cnt += int'(MemStall);
    check("sw wait done req", 32'(MemReq), 32'd0);
    check("sw wait stall cycles", 32'(stall_cnt), 32'd7);
    step();
    MemRead = 3'd5;
    AluRes = 32'h100;
    MemRData = 32'h11223344;
    MemReady = 1'b0;
    step();
    check("rst lw t1 req", 32'(MemReq), 32'd1);
    step();
    check("rst lw t2 req", 32'(MemReq), 32'd1);
    Reset = 1'b1;
    MemRead = 3'd0;
    MemReady = 1'b1;
    step();
    Reset = 1'b0;
    MemReady = 1'b0;
    check("rst lw req", 32'(MemReq), 32'd0);
    check("rst lw stall", 32'(MemStall), 32'd0);
    check("rst lw valid", 32'(LoadValid), 32'd0);
    check("rst lw ldata", LoadData, 32'd0);
    valid_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      valid_cnt += int'(LoadValid);
    end
    check("rst lw no valid", 32'(valid_cnt), 32'd0);
    do_store("sw after rst", 2'd3, 32'h44, 32'h55AA55AA, 4'b1111, 32'h55AA55AA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the CPU data-memory interface, placed in the MEM stage between the EX/MEM pipeline register and a word-wide, multi-cycle data memory. It accepts the pipeline's MemWrite/MemRead encodings and checks alignment. It issues one request per access over a req/ready handshake, steering store data onto the correct byte lanes with byte enables. It extracts and extends load data, and stalls the pipeline until the access completes.

## Interface
Parameters: none; all widths are fixed.

Ports:
- Clock  in  1  system clock; every flop updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- AluRes  in  32  effective byte address
- InputData  in  32  store data, justified to bit 0
- MemWrite  in  2  2'b01 sb, 2'b10 sh, 2'b11 sw, 2'b00 no store
- MemRead  in  3  3'b001 lb, 3'b010 lbu, 3'b011 lh, 3'b100 lhu, 3'b101 lw; 0/6/7 mean no load
- MemStall  out  1  freezes the upstream pipeline
- LoadData  out  32  extended load result
- LoadValid  out  1  one-cycle pulse when LoadData is updated
- MisalignErr  out  1  one-cycle pulse on a misaligned access
- MemReq  out  1  request valid
- MemWe  out  1  1 = write, 0 = read
- MemAddr  out  30  word address, AluRes[31:2]
- MemBe  out  4  byte enables; bit i covers MemWData[8i+7:8i]
- MemWData  out  32  lane-replicated store data
- MemReady  in  1  memory accepts or completes the request in this cycle
- MemRData  in  32  read word, valid when MemReady=1 and MemWe=0

## Operation
- Access detection: an access exists when MemWrite!=0 or MemRead is in 1..5.
  - If both are active, the write wins and MemRead is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, access present and aligned:
  - Register MemAddr, MemWe, MemBe and MemWData; go to REQ.
- IDLE, access present but misaligned:
  - Misaligned means any nonzero AluRes[1:0] for sw/lw, or AluRes[0]=1 for sh/lh/lhu.
  - Pulse MisalignErr on the next cycle; issue no request; stay in IDLE.
- REQ:
  - Hold MemReq=1 with all Mem* outputs stable until MemReady=1.
  - On MemReady=1 for a read, capture the extended load result into LoadData.
  - On MemReady=1, go to DONE.
- DONE: for reads, LoadValid=1; return to IDLE unconditionally.
- Store lane steering, with off = AluRes[1:0]:
  - sb: MemBe = 4'b0001<<off; MemWData = {4{InputData[7:0]}}.
  - sh: MemBe = AluRes[1] ? 4'b1100 : 4'b0011; MemWData = {2{InputData[15:0]}}.
  - sw: MemBe = 4'b1111; MemWData = InputData.
  - Reads: MemBe = 4'b1111; MemWData = 0.
- Load extraction:
  - Byte loads take MemRData[8*off+7:8*off]; halfword loads take MemRData[16*AluRes[1]+15:16*AluRes[1]].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word unchanged.
- LoadData holds its value until the next completed load.
- MemReady is ignored in IDLE and DONE.

## Timing
- Reset values: all outputs 0 (MemStall, LoadData, LoadValid, MisalignErr, MemReq, MemWe, MemAddr, MemBe, MemWData); FSM in IDLE.
- MemStall:
  - Combinationally 1 in IDLE when an aligned access is present.
  - 1 throughout REQ.
  - 0 in DONE, so the pipeline advances at the end of DONE. The next instruction is therefore never mistaken for the old one.
- Minimum access with MemReady=1 in the first REQ cycle:
  - t0 = IDLE accept; t1 = REQ; t2 = DONE with LoadValid.
  - This is 3 cycles and 2 stall cycles.
  - Each extra cycle of MemReady=0 adds one cycle.
- MemReq rises in the cycle after accept and falls in the cycle after MemReady=1.
- Misaligned access costs 1 cycle: MisalignErr pulses at t1 with MemStall=0 at t0.
- Reset asserted in any state:
  - Next cycle: state IDLE, MemReq=0, MemStall=0, LoadValid=0, LoadData=0.
  - The memory must tolerate an abandoned request.
- Back-to-back accesses: a new access can be accepted in the cycle after DONE.

## Test plan
- sb, AluRes=0x103, InputData=0x000000A5, MemReady=1 at t1:
  - MemAddr=0x40, MemWe=1, MemBe=4'b1000, MemWData=0xA5A5A5A5.
  - MemStall=1 at t0 and t1, 0 at t2.
- lb and then lbu, AluRes=0x102, MemRData=0x12F03456:
  - lb gives LoadData=0xFFFFFFF0; lbu gives 0x000000F0.
  - LoadValid pulses one cycle at t2 each time.
- lh, AluRes=0x206, MemRData=0x80017FFF:
  - LoadData=0xFFFF8001.
  - lhu at 0x204 with the same word gives 0x00007FFF.
- lw, AluRes=0x101:
  - MisalignErr=1 for exactly one cycle.
  - MemReq never rises; MemStall stays 0.
- sw at 0x40, MemReady held 0 for 5 REQ cycles then 1:
  - MemReq=1 with MemAddr=0x10, MemBe=4'b1111 and MemWData stable for 6 cycles.
  - MemStall=1 for 7 cycles.
- Reset in the second REQ cycle of a pending lw:
  - Next cycle MemReq=0, MemStall=0, LoadValid never pulses.
  - A following sw completes normally in 3 cycles.
